ssl_xcorr_ctrl: RTL and testbench

- Sequences one localization frame.
- Waits for the input buffer to capture a fresh NDATA-sample frame, then freezes the buffer.
- Time-shares the single cross-correlator across the three pairs Ref-A, Ref-B and Ref-C, sweeping every lag.
- Reports the peak-score lag per channel with a valid/ready handshake. Sits between counter/input_buff and the correlator/direction solver.

---
 rtl/ssl_pkg.sv | 9 +
 rtl/ssl_xcorr_ctrl_if.sv | 15 +
 rtl/ssl_peak_tracker.sv | 33 +++
 rtl/ssl_xcorr_ctrl.sv | 90 +++++++++
 tb/tb_ssl_xcorr_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/ssl_pkg.sv
// ssl_pkg: shared states, channel codes and frame defaults for the localization pipeline
package ssl_pkg;
  localparam int SSL_NDATA = 128;
  localparam int SSL_MAXLAG = 16;
  typedef enum logic [2:0] {IDLE, SYNC, FILL, SWEEP, DONE} state_t;
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
endpackage

// File: rtl/ssl_xcorr_ctrl_if.sv
// ssl_xcorr_ctrl_if: correlator request/score bus and peak-lag result handshake
interface ssl_xcorr_ctrl_if #(parameter int LAG_W = 6, parameter int SCORE_W = 8);
  logic corr_req;
  logic [1:0] corr_ch;
  logic signed [LAG_W-1:0] corr_lag;
  logic corr_ack;
  logic [SCORE_W-1:0] corr_score;
  logic signed [LAG_W-1:0] lag_a, lag_b, lag_c;
  logic res_valid;
  logic res_ready;
  modport master(output corr_req, corr_ch, corr_lag, lag_a, lag_b, lag_c, res_valid,
                 input corr_ack, corr_score, res_ready);
  modport slave(input corr_req, corr_ch, corr_lag, lag_a, lag_b, lag_c, res_valid,
                output corr_ack, corr_score, res_ready);
endinterface

// File: rtl/ssl_peak_tracker.sv
// ssl_peak_tracker: running max of scores; first update after clr loads, ties keep the earlier lag
module ssl_peak_tracker #(
  parameter int LAG_W = 6,
  parameter int SCORE_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic clr,
  input  logic upd,
  input  logic [SCORE_W-1:0] score,
  input  logic signed [LAG_W-1:0] lag,
  output logic signed [LAG_W-1:0] peak_lag
);
  logic empty, load;
  logic [SCORE_W-1:0] best_score;
  logic signed [LAG_W-1:0] best_lag;
  assign load = upd && (empty || score > best_score);
  // bypass so the final lag of a channel is visible in the same cycle it arrives
  assign peak_lag = load ? lag : best_lag;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      empty <= 1'b1;
      best_score <= '0;
      best_lag <= '0;
    end else if (ena) begin
      empty <= clr | (empty & ~load);
      if (load) begin
        best_score <= score;
        best_lag <= lag;
      end
    end
endmodule

// File: rtl/ssl_xcorr_ctrl.sv
// ssl_xcorr_ctrl: frames a fresh buffer, sweeps all lags of three pairs through one
// correlator and reports the per-channel peak lag over a valid/ready handshake
module ssl_xcorr_ctrl
  import ssl_pkg::*;
#(
  parameter int NDATA = SSL_NDATA,
  parameter int MAXLAG = SSL_MAXLAG,
  localparam int NDATA_LOG = $clog2(NDATA),
  localparam int LAG_W = $clog2(MAXLAG) + 2,
  localparam int SCORE_W = NDATA_LOG + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic [NDATA_LOG-1:0] cntin,
  input  logic start,
  input  logic cont,
  output logic freeze,
  output logic busy,
  ssl_xcorr_ctrl_if.master bus
);
  localparam logic signed [LAG_W-1:0] LAG_MIN = LAG_W'(-MAXLAG);
  localparam logic signed [LAG_W-1:0] LAG_MAX = LAG_W'(MAXLAG);
  state_t state;
  logic xfer, last_lag;
  logic signed [LAG_W-1:0] peak_lag;
  assign xfer = ena && bus.corr_req && bus.corr_ack;
  assign last_lag = bus.corr_lag == LAG_MAX;
  ssl_peak_tracker #(.LAG_W(LAG_W), .SCORE_W(SCORE_W)) u_peak (
    .clk, .rst, .ena,
    .clr(xfer && last_lag),
    .upd(xfer),
    .score(bus.corr_score),
    .lag(bus.corr_lag),
    .peak_lag
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      freeze <= 1'b0;
      busy <= 1'b0;
      bus.corr_req <= 1'b0;
      bus.corr_ch <= CH_A;
      bus.corr_lag <= '0;
      bus.lag_a <= '0;
      bus.lag_b <= '0;
      bus.lag_c <= '0;
      bus.res_valid <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: if (start) begin
          state <= SYNC;
          busy <= 1'b1;
        end
        SYNC: if (cntin == '0) state <= FILL;
        // the frame is complete once the last sample index has been written
        FILL: if (cntin == NDATA_LOG'(NDATA - 1)) begin
          state <= SWEEP;
          freeze <= 1'b1;
          bus.corr_req <= 1'b1;
          bus.corr_ch <= CH_A;
          bus.corr_lag <= LAG_MIN;
        end
        SWEEP: if (xfer) begin
          if (last_lag) begin
            if (bus.corr_ch == CH_A) bus.lag_a <= peak_lag;
            if (bus.corr_ch == CH_B) bus.lag_b <= peak_lag;
            if (bus.corr_ch == CH_C) bus.lag_c <= peak_lag;
            if (bus.corr_ch == CH_C) begin
              bus.corr_req <= 1'b0;
              bus.res_valid <= 1'b1;
              state <= DONE;
            end else begin
              bus.corr_ch <= bus.corr_ch + 2'd1;
              bus.corr_lag <= LAG_MIN;
            end
          end else begin
            bus.corr_lag <= bus.corr_lag + LAG_W'(1);
          end
        end
        DONE: if (bus.res_valid && bus.res_ready) begin
          bus.res_valid <= 1'b0;
          freeze <= 1'b0;
          state <= cont ? SYNC : IDLE;
          busy <= cont;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ssl_xcorr_ctrl.sv
// tb_ssl_xcorr_ctrl: directed frames against a small correlator model with hand-computed peak lags
module tb_ssl_xcorr_ctrl;
  logic clk = 0, rst = 0, ena = 1, start = 0, cont = 0;
  logic freeze, busy;
  logic [6:0] cntin = 0;
  int checks = 0, errors = 0, nxfer = 0, mode = 0, stall_n = 0;
  bit stall_en = 0;
  typedef struct {int mode; int ea; int eb; int ec;} vec_t;
  vec_t tbl[4];

  ssl_xcorr_ctrl_if #(.LAG_W(6), .SCORE_W(8)) bus();

  ssl_xcorr_ctrl u_dut (
    .clk(clk), .rst(rst), .ena(ena), .cntin(cntin), .start(start), .cont(cont),
    .freeze(freeze), .busy(busy), .bus(bus.master)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cntin = cntin + 1;

  always @(negedge clk) begin
    bus.corr_ack = !(stall_en && bus.corr_ch == 2'd1 && bus.corr_lag == -6'sd2 && stall_n < 5);
    if (!bus.corr_ack) stall_n++;
  end

  function automatic logic [7:0] model(int md, logic [1:0] ch, logic signed [5:0] lag);
    int l, pk, d;
    l = lag;
    if (md == 1) return 8'd64;
    if (md == 2) return (l == 7 || l == 9) ? 8'd200 : 8'd10;
    pk = md == 0 ? (ch == 0 ? 3 : ch == 1 ? -5 : 0) : (ch == 0 ? -16 : ch == 1 ? 16 : 1);
    d = l > pk ? l - pk : pk - l;
    return 8'(200 - 4 * d);
  endfunction

  always_comb bus.corr_score = model(mode, bus.corr_ch, bus.corr_lag);

  always @(posedge clk) if (rst && ena && bus.corr_req && bus.corr_ack) nxfer++;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic start_fill(bit do_start);
    int c;
    if (do_start) begin
      @(negedge clk); start = 1;
      @(posedge clk); #1 start = 0;
    end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (cntin == 0) break;
    end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      c = cntin;
      #1;
      if (c == 126) chk("freeze_before_last", freeze, 0);
      if (c == 127) break;
    end
    chk("freeze_rise", freeze, 1);
    chk("req_rise", bus.corr_req, 1);
    chk("first_lag", bus.corr_lag, -16);
    chk("first_ch", bus.corr_ch, 0);
  endtask

  task automatic finish_frame(vec_t v, bit bp, bit cb, int base);
    bit found = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.res_valid) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("res_valid_seen", found, 1);
    chk("lag_a", bus.lag_a, v.ea);
    chk("lag_b", bus.lag_b, v.eb);
    chk("lag_c", bus.lag_c, v.ec);
    chk("transfers", nxfer - base, 99);
    chk("req_done", bus.corr_req, 0);
    if (bp) repeat (10) begin
      @(posedge clk); #1;
      chk("bp_valid", bus.res_valid, 1);
      chk("bp_freeze", freeze, 1);
    end
    @(negedge clk); bus.res_ready = 1; cont = cb;
    @(posedge clk); #1;
    chk("hs_valid", bus.res_valid, 0);
    chk("hs_freeze", freeze, 0);
    chk("hs_busy", busy, int'(cb));
    bus.res_ready = 0; cont = 0;
  endtask

  initial begin
    int base, lg, n0;
    bit hit;
    tbl[0] = '{0, 3, -5, 0};
    tbl[1] = '{1, -16, -16, -16};
    tbl[2] = '{2, 7, 7, 7};
    tbl[3] = '{3, -16, 16, 1};
    bus.res_ready = 0;
    #12;
    chk("rst_freeze", freeze, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", bus.corr_req, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_lag_a", bus.lag_a, 0);
    chk("rst_corr_lag", bus.corr_lag, 0);
    @(negedge clk); rst = 1;
    repeat (3) @(posedge clk);
    #1 chk("idle_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      base = nxfer;
      start_fill(1);
      finish_frame(tbl[i], 0, 0, base);
    end
    mode = 0; base = nxfer;
    start_fill(1);
    finish_frame(tbl[0], 1, 1, base);
    mode = 3; base = nxfer;
    start_fill(0);
    finish_frame(tbl[3], 0, 0, base);
    mode = 0; stall_en = 1; base = nxfer;
    start_fill(1);
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      if (bus.corr_ch == 2'd1 && bus.corr_lag == -6'sd2) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    chk("stall_reached", hit, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_req", bus.corr_req, 1);
      chk("stall_ch", bus.corr_ch, 1);
      chk("stall_lag", bus.corr_lag, -2);
    end
    @(posedge clk); #1 chk("stall_resume", bus.corr_lag, -1);
    repeat (3) @(posedge clk);
    @(negedge clk); ena = 0; lg = bus.corr_lag; n0 = nxfer;
    repeat (8) @(negedge clk);
    chk("ena_lag", bus.corr_lag, lg);
    chk("ena_xfer", nxfer, n0);
    chk("ena_req", bus.corr_req, 1);
    chk("ena_freeze", freeze, 1);
    ena = 1;
    finish_frame(tbl[0], 0, 0, base);
    start_fill(1);
    repeat (20) @(posedge clk);
    #3 rst = 0;
    #1;
    chk("arst_freeze", freeze, 0);
    chk("arst_req", bus.corr_req, 0);
    chk("arst_valid", bus.res_valid, 0);
    chk("arst_lag_a", bus.lag_a, 0);
    chk("arst_lag_b", bus.lag_b, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk); rst = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_freeze", freeze, 0);
    chk("post_rst_req", bus.corr_req, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
